// File: rtl/poly_bank_ctrl.sv
// Polynomial RAM bank: NUM_SLOTS slots of N coefficients each. Port A gives the host
// coefficient I/O; port B is owned by an engine running CLEAR/COPY/ADD/SUB over whole slots.
module poly_bank_ctrl #(
  parameter int NUM_SLOTS = 20,
  parameter int N         = 256,
  parameter int COEFF_W   = 12,
  parameter int Q         = 3329,
  parameter int SLOT_W    = 5,
  parameter int ADDR_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               host_we,
  input  logic [SLOT_W-1:0]  host_slot,
  input  logic [ADDR_W-1:0]  host_addr,
  input  logic [COEFF_W-1:0] host_din,
  output logic [COEFF_W-1:0] host_dout,
  output logic               host_wr_drop,
  input  logic               op_start,
  input  logic [1:0]         op_code,
  input  logic [SLOT_W-1:0]  op_src_a,
  input  logic [SLOT_W-1:0]  op_src_b,
  input  logic [SLOT_W-1:0]  op_dst,
  output logic               op_ready,
  output logic               op_done,
  output logic               op_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;
  typedef enum logic [1:0] {OP_CLEAR = 2'b00, OP_COPY = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11} op_t;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [COEFF_W:0]  Q_EXT     = (COEFF_W + 1)'(Q);

  logic [COEFF_W-1:0] mem [NUM_SLOTS][N];

  state_t             state;
  op_t                op_q;
  logic [SLOT_W-1:0]  src_a_q, src_b_q, dst_q;
  logic [ADDR_W-1:0]  rd_cnt, wr_idx;
  logic               wr_vld;
  logic [COEFF_W-1:0] rd_a, rd_b;

  // Request decode: which sources the requested op reads, and whether it is legal.
  op_t  req_op;
  logic req_reads_a, req_reads_b, req_legal;
  assign req_op = op_t'(op_code);

  // NOTE: every always_comb output gets a default before any conditional update,
  // otherwise a missed branch infers a latch.
  always_comb begin
    req_reads_a = (req_op != OP_CLEAR);
    req_reads_b = (req_op == OP_ADD) || (req_op == OP_SUB);
    req_legal   = (op_dst <= LAST_SLOT);
    if (req_reads_a && ((op_src_a > LAST_SLOT) || (op_src_a == op_dst))) req_legal = 1'b0;
    if (req_reads_b && ((op_src_b > LAST_SLOT) || (op_src_b == op_dst))) req_legal = 1'b0;
  end

  // Host writes are blocked from any slot the running op reads or writes.
  logic busy, act_reads_a, act_reads_b, host_slot_ok, host_conflict, host_wr_en;
  always_comb begin
    busy          = (state == ST_RUN) || (state == ST_DRAIN);
    act_reads_a   = (op_q != OP_CLEAR);
    act_reads_b   = (op_q == OP_ADD) || (op_q == OP_SUB);
    host_slot_ok  = (host_slot <= LAST_SLOT);
    host_conflict = busy && ((host_slot == dst_q) ||
                             (act_reads_a && (host_slot == src_a_q)) ||
                             (act_reads_b && (host_slot == src_b_q)));
    host_wr_en    = host_we && host_slot_ok && !host_conflict;
  end

  // Modular ALU: operands are canonical, so one conditional correction suffices.
  logic [COEFF_W:0]   sum, diff;
  logic [COEFF_W-1:0] wr_data;
  always_comb begin
    sum  = {1'b0, rd_a} + {1'b0, rd_b};
    diff = {1'b0, rd_a} - {1'b0, rd_b};
    unique case (op_q)
      OP_CLEAR: wr_data = '0;
      OP_COPY:  wr_data = rd_a;
      OP_ADD:   wr_data = (sum >= Q_EXT) ? COEFF_W'(sum - Q_EXT) : sum[COEFF_W-1:0];
      OP_SUB:   wr_data = diff[COEFF_W] ? COEFF_W'(diff + Q_EXT) : diff[COEFF_W-1:0];
      default:  wr_data = '0;
    endcase
  end

  // NOTE: the RAM array has no reset; its contents survive rst_n and a reset
  // term here would stop it mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (host_wr_en) mem[host_slot][host_addr] <= host_din;
    if (wr_vld)     mem[dst_q][wr_idx]        <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_dout    <= '0;
      host_wr_drop <= 1'b0;
    end else begin
      host_dout    <= host_slot_ok ? mem[host_slot][host_addr] : '0;
      host_wr_drop <= host_we && host_slot_ok && host_conflict;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= OP_CLEAR;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      rd_cnt   <= '0;
      wr_idx   <= '0;
      wr_vld   <= 1'b0;
      rd_a     <= '0;
      rd_b     <= '0;
      op_ready <= 1'b1;
      op_done  <= 1'b0;
      op_err   <= 1'b0;
    end else begin
      op_done <= 1'b0;
      op_err  <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          state    <= ST_IDLE;
          op_ready <= 1'b1;
          if (op_start && op_ready) begin
            if (req_legal) begin
              op_q     <= req_op;
              src_a_q  <= op_src_a;
              src_b_q  <= op_src_b;
              dst_q    <= op_dst;
              rd_cnt   <= '0;
              op_ready <= 1'b0;
              state    <= ST_RUN;
            end else begin
              op_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          rd_a   <= act_reads_a ? mem[src_a_q][rd_cnt] : '0;
          rd_b   <= act_reads_b ? mem[src_b_q][rd_cnt] : '0;
          wr_idx <= rd_cnt;
          wr_vld <= 1'b1;
          rd_cnt <= rd_cnt + 1'b1;
          if (rd_cnt == LAST_ADDR) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Final write-back (index N-1) lands on this edge.
          wr_vld   <= 1'b0;
          op_done  <= 1'b1;
          op_ready <= 1'b1;
          state    <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_bank_ctrl.sv
// Directed bench for poly_bank_ctrl: host I/O, slot ops, rejects, write drops and mid-op reset.
module tb_poly_bank_ctrl;
  localparam int NUM_SLOTS = 20;
  localparam int N         = 256;
  localparam int COEFF_W   = 12;
  localparam int Q         = 3329;
  localparam int SLOT_W    = 5;
  localparam int ADDR_W    = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               host_we;
  logic [SLOT_W-1:0]  host_slot;
  logic [ADDR_W-1:0]  host_addr;
  logic [COEFF_W-1:0] host_din;
  logic [COEFF_W-1:0] host_dout;
  logic               host_wr_drop;
  logic               op_start;
  logic [1:0]         op_code;
  logic [SLOT_W-1:0]  op_src_a, op_src_b, op_dst;
  logic               op_ready, op_done, op_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [COEFF_W-1:0] rd_buf [N];

  always #5 clk = ~clk;

  poly_bank_ctrl #(
    .NUM_SLOTS(NUM_SLOTS), .N(N), .COEFF_W(COEFF_W), .Q(Q), .SLOT_W(SLOT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .host_we(host_we), .host_slot(host_slot), .host_addr(host_addr), .host_din(host_din),
    .host_dout(host_dout), .host_wr_drop(host_wr_drop),
    .op_start(op_start), .op_code(op_code), .op_src_a(op_src_a), .op_src_b(op_src_b),
    .op_dst(op_dst), .op_ready(op_ready), .op_done(op_done), .op_err(op_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [SLOT_W-1:0] slot, input logic [ADDR_W-1:0] addr,
                            input logic [COEFF_W-1:0] din);
    host_we = 1'b1; host_slot = slot; host_addr = addr; host_din = din;
    tick();
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [SLOT_W-1:0] slot, input logic [ADDR_W-1:0] addr,
                           output logic [COEFF_W-1:0] d);
    host_slot = slot; host_addr = addr;
    tick();
    d = host_dout;
  endtask

  task automatic fill_const(input logic [SLOT_W-1:0] slot, input logic [COEFF_W-1:0] v);
    for (int i = 0; i < N; i++) host_write(slot, ADDR_W'(i), v);
  endtask

  task automatic fill_index(input logic [SLOT_W-1:0] slot);
    for (int i = 0; i < N; i++) host_write(slot, ADDR_W'(i), COEFF_W'(i));
  endtask

  task automatic dump_slot(input logic [SLOT_W-1:0] slot);
    logic [COEFF_W-1:0] d;
    for (int i = 0; i < N; i++) begin
      host_read(slot, ADDR_W'(i), d);
      rd_buf[i] = d;
    end
  endtask

  task automatic start_op(input logic [1:0] code, input logic [SLOT_W-1:0] a,
                          input logic [SLOT_W-1:0] b, input logic [SLOT_W-1:0] dst);
    op_start = 1'b1; op_code = code; op_src_a = a; op_src_b = b; op_dst = dst;
    tick();
    op_start = 1'b0;
  endtask

  // Counts edges until op_done is seen; -1 if the budget expires.
  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (op_done === 1'b1) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; host_we = 1'b0; host_slot = '0; host_addr = '0; host_din = '0;
    op_start = 1'b0; op_code = '0; op_src_a = '0; op_src_b = '0; op_dst = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n_tests++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", op_ready); end
    n_tests++; if (op_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", op_done); end
    n_tests++; if (op_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", op_err); end
    n_tests++; if (host_wr_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", host_wr_drop); end
    n_tests++; if (host_dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h want 000", host_dout); end
  endtask

  task automatic test_host_io();
    logic [COEFF_W-1:0] d;
    host_write(5'd19, 8'd255, 12'h123);
    n_tests++; if (host_wr_drop !== 1'b0) begin n_fail++; $display("FAIL host_wr_nodrop: got %b want 0", host_wr_drop); end
    host_read(5'd19, 8'd255, d);
    n_tests++; if (d !== 12'h123) begin n_fail++; $display("FAIL host_rd_19_255: got %h want 123", d); end
    host_write(5'd20, 8'd0, 12'hABC);
    n_tests++; if (host_wr_drop !== 1'b0) begin n_fail++; $display("FAIL host_wr_slot20_drop: got %b want 0", host_wr_drop); end
    host_read(5'd20, 8'd0, d);
    n_tests++; if (d !== 12'h000) begin n_fail++; $display("FAIL host_rd_slot20: got %h want 000", d); end
    host_read(5'd31, 8'd7, d);
    n_tests++; if (d !== 12'h000) begin n_fail++; $display("FAIL host_rd_slot31: got %h want 000", d); end
  endtask

  task automatic test_copy();
    int cyc, bad;
    fill_index(5'd0);
    start_op(2'b01, 5'd0, 5'd0, 5'd3);
    n_tests++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL copy_ready_low: got %b want 0", op_ready); end
    wait_done(cyc);
    n_tests++; if (cyc !== 257) begin n_fail++; $display("FAIL copy_latency: got %0d want 257", cyc); end
    n_tests++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL copy_ready_at_done: got %b want 1", op_ready); end
    tick();
    n_tests++; if (op_done !== 1'b0) begin n_fail++; $display("FAIL copy_done_width: got %b want 0", op_done); end
    dump_slot(5'd3);
    bad = -1;
    for (int i = 0; i < N; i++) if (bad < 0 && rd_buf[i] !== COEFF_W'(i)) bad = i;
    n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL copy_dst: slot3[%0d] got %0d want %0d", bad, rd_buf[bad], bad); end
    dump_slot(5'd0);
    bad = -1;
    for (int i = 0; i < N; i++) if (bad < 0 && rd_buf[i] !== COEFF_W'(i)) bad = i;
    n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL copy_src_kept: slot0[%0d] got %0d want %0d", bad, rd_buf[bad], bad); end
  endtask

  task automatic test_add();
    int cyc, bad;
    fill_const(5'd1, 12'd3328);
    fill_const(5'd2, 12'd5);
    start_op(2'b10, 5'd1, 5'd2, 5'd4);
    wait_done(cyc);
    n_tests++; if (cyc !== 257) begin n_fail++; $display("FAIL add_latency: got %0d want 257", cyc); end
    tick();
    dump_slot(5'd4);
    bad = -1;
    for (int i = 0; i < N; i++) if (bad < 0 && rd_buf[i] !== 12'd4) bad = i;
    n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL add_1_2: slot4[%0d] got %0d want 4", bad, rd_buf[bad]); end
  endtask

  // ADD(1,1)->6, then SUB(2,1)->5 accepted in the very cycle op_done is high.
  task automatic test_back_to_back();
    int cyc, bad;
    start_op(2'b10, 5'd1, 5'd1, 5'd6);
    wait_done(cyc);
    n_tests++; if (cyc !== 257) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 257", cyc); end
    start_op(2'b11, 5'd2, 5'd1, 5'd5);
    n_tests++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: ready got %b want 0", op_ready); end
    wait_done(cyc);
    n_tests++; if (cyc !== 257) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 257", cyc); end
    tick();
    dump_slot(5'd6);
    bad = -1;
    for (int i = 0; i < N; i++) if (bad < 0 && rd_buf[i] !== 12'd3327) bad = i;
    n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL add_1_1: slot6[%0d] got %0d want 3327", bad, rd_buf[bad]); end
    dump_slot(5'd5);
    bad = -1;
    for (int i = 0; i < N; i++) if (bad < 0 && rd_buf[i] !== 12'd6) bad = i;
    n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL sub_2_1: slot5[%0d] got %0d want 6", bad, rd_buf[bad]); end
  endtask

  task automatic test_reject();
    int cyc, bad, total;
    logic [COEFF_W-1:0] d;
    start_op(2'b01, 5'd2, 5'd0, 5'd2);
    n_tests++; if (op_err !== 1'b1) begin n_fail++; $display("FAIL rej_copy_alias_err: got %b want 1", op_err); end
    n_tests++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL rej_copy_alias_ready: got %b want 1", op_ready); end
    tick();
    n_tests++; if (op_err !== 1'b0) begin n_fail++; $display("FAIL rej_err_width: got %b want 0", op_err); end
    start_op(2'b10, 5'd1, 5'd2, 5'd20);
    n_tests++; if (op_err !== 1'b1) begin n_fail++; $display("FAIL rej_add_dst20_err: got %b want 1", op_err); end
    n_tests++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL rej_add_dst20_ready: got %b want 1", op_ready); end
    tick();
    dump_slot(5'd2);
    bad = -1;
    for (int i = 0; i < N; i++) if (bad < 0 && rd_buf[i] !== 12'd5) bad = i;
    n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL rej_slot2_kept: slot2[%0d] got %0d want 5", bad, rd_buf[bad]); end

    // op_start while busy must be ignored: no error, no effect on slot 8.
    host_write(5'd8, 8'd0, 12'h321);
    start_op(2'b01, 5'd0, 5'd0, 5'd7);
    repeat (10) tick();
    op_start = 1'b1; op_code = 2'b00; op_dst = 5'd8;
    tick();
    n_tests++; if (op_err !== 1'b0) begin n_fail++; $display("FAIL busy_start_err: got %b want 0", op_err); end
    tick();
    op_start = 1'b0;
    wait_done(cyc);
    total = (cyc < 0) ? -1 : cyc + 12;
    n_tests++; if (total !== 257) begin n_fail++; $display("FAIL busy_start_latency: got %0d want 257", total); end
    repeat (5) tick();
    n_tests++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL busy_start_idle: ready got %b want 1", op_ready); end
    host_read(5'd8, 8'd0, d);
    n_tests++; if (d !== 12'h321) begin n_fail++; $display("FAIL busy_start_slot8: got %h want 321", d); end
    host_read(5'd7, 8'd200, d);
    n_tests++; if (d !== 12'd200) begin n_fail++; $display("FAIL busy_copy_slot7: got %0d want 200", d); end
  endtask

  task automatic test_wr_drop();
    int cyc;
    logic [COEFF_W-1:0] d;
    start_op(2'b10, 5'd1, 5'd2, 5'd4);
    repeat (5) tick();
    host_write(5'd4, 8'd10, 12'h055);
    n_tests++; if (host_wr_drop !== 1'b1) begin n_fail++; $display("FAIL drop_dst: got %b want 1", host_wr_drop); end
    host_write(5'd1, 8'd20, 12'h007);
    n_tests++; if (host_wr_drop !== 1'b1) begin n_fail++; $display("FAIL drop_src: got %b want 1", host_wr_drop); end
    host_write(5'd9, 8'd30, 12'h099);
    n_tests++; if (host_wr_drop !== 1'b0) begin n_fail++; $display("FAIL drop_other: got %b want 0", host_wr_drop); end
    wait_done(cyc);
    n_tests++; if (cyc < 0) begin n_fail++; $display("FAIL drop_op_done: timed out"); end
    tick();
    host_read(5'd4, 8'd10, d);
    n_tests++; if (d !== 12'd4) begin n_fail++; $display("FAIL drop_dst_data: got %0d want 4", d); end
    host_read(5'd1, 8'd20, d);
    n_tests++; if (d !== 12'd3328) begin n_fail++; $display("FAIL drop_src_data: got %0d want 3328", d); end
    host_read(5'd9, 8'd30, d);
    n_tests++; if (d !== 12'h099) begin n_fail++; $display("FAIL drop_other_data: got %h want 099", d); end
  endtask

  task automatic test_reset_mid_op();
    int cyc, dones, bad;
    fill_const(5'd10, 12'h111);
    start_op(2'b00, 5'd0, 5'd0, 5'd10);
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    n_tests++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", op_ready); end
    repeat (2) tick();
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (op_done === 1'b1) dones++;
    end
    n_tests++; if (dones !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses want 0", dones); end
    dump_slot(5'd10);
    n_tests++; if (rd_buf[98] !== 12'h000) begin n_fail++; $display("FAIL midrst_cleared_98: got %h want 000", rd_buf[98]); end
    n_tests++; if (rd_buf[150] !== 12'h111) begin n_fail++; $display("FAIL midrst_kept_150: got %h want 111", rd_buf[150]); end
    n_tests++; if (rd_buf[255] !== 12'h111) begin n_fail++; $display("FAIL midrst_kept_255: got %h want 111", rd_buf[255]); end
    start_op(2'b00, 5'd0, 5'd0, 5'd10);
    wait_done(cyc);
    n_tests++; if (cyc !== 257) begin n_fail++; $display("FAIL clear_latency: got %0d want 257", cyc); end
    tick();
    dump_slot(5'd10);
    bad = -1;
    for (int i = 0; i < N; i++) if (bad < 0 && rd_buf[i] !== 12'h000) bad = i;
    n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL clear_all: slot10[%0d] got %h want 000", bad, rd_buf[bad]); end
  endtask

  initial begin
    test_reset();
    test_host_io();
    test_copy();
    test_add();
    test_back_to_back();
    test_reject();
    test_wr_drop();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/poly_bank_ctrl.md
Name: poly_bank_ctrl

Overview:
Parametrised polynomial RAM bank: NUM_SLOTS dual-port slots of N×COEFF_W each. Port A serves host coefficient I/O. Port B is driven by an internal slot-op engine that runs whole-polynomial CLEAR, COPY, ADD mod Q and SUB mod Q. The block sits under the top-level controller as the storage-plus-elementwise-ALU layer that later NTT and sampler micro-ops build on.

Parameters:
NUM_SLOTS, 20, number of polynomial slots
N, 256, coefficients per slot (power of two)
COEFF_W, 12, coefficient width
Q, 3329, modulus for ADD/SUB
SLOT_W, 5, slot index width (2^SLOT_W >= NUM_SLOTS)
ADDR_W, 8, log2(N)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
host_we  in  1  host write strobe
host_slot  in  SLOT_W  host slot select
host_addr  in  ADDR_W  coefficient index
host_din  in  COEFF_W  write data
host_dout  out  COEFF_W  read data, 1-cycle latency
host_wr_drop  out  1  pulse: host write discarded
op_start  in  1  request slot op
op_code  in  2  00 CLEAR, 01 COPY, 10 ADD, 11 SUB
op_src_a  in  SLOT_W  first source slot
op_src_b  in  SLOT_W  second source slot (ADD/SUB only)
op_dst  in  SLOT_W  destination slot
op_ready  out  1  engine idle, can accept
op_done  out  1  one-cycle completion pulse
op_err  out  1  one-cycle rejection pulse

Behaviour:
- Reset: op_ready=1, op_done=0, op_err=0, host_wr_drop=0, host_dout=0, FSM=IDLE, counters=0. RAM contents are not cleared.
- Host write: on host_we, write host_din to host_slot[host_addr].
  - host_slot >= NUM_SLOTS: write ignored, no drop pulse.
  - Target slot is op_dst, op_src_a or op_src_b of the active op: write discarded; host_wr_drop=1 the next cycle.
- Host read: always allowed, including slots busy with an op.
  - host_dout = data at the address presented last cycle, from the slot registered last cycle.
  - Registered slot >= NUM_SLOTS: host_dout = 0.
- Op accept: op_start & op_ready at an edge, all slots valid, and dst differs from every source the op reads.
  - CLEAR reads no source.
  - COPY reads src_a.
  - ADD/SUB read src_a and src_b. src_a == src_b is allowed.
  - Operands are latched at accept.
- Op reject: op_start & op_ready with an invalid slot or dst aliasing a read source. Result: op_err=1 next cycle, stays IDLE, no RAM write.
- op_start while op_ready=0 is ignored silently.
- FSM states:
  - IDLE -> RUN on accept.
  - RUN: read address counter 0..N-1 on port B of the sources. Write-back runs one cycle behind, to dst port B, at the same index. After issuing read N-1 -> DRAIN.
  - DRAIN: final write (index N-1) -> DONE.
  - DONE: op_done=1 for one cycle, op_ready=1, -> IDLE.
- Timing: accept at edge 0. op_ready low from edge 1. Last dst write at edge N+1. op_done and op_ready high after edge N+1. A new op can be accepted at edge N+2.
- Arithmetic, inputs canonical (< Q):
  - ADD: s = a + b, computed COEFF_W+1 wide; subtract Q if s >= Q.
  - SUB: d = a - b; add Q if negative.
  - COPY: dst = a.
  - CLEAR: dst = 0.
  - Results are always in [0, Q-1].
- Read/write collision: a host port-A read of dst during an op returns either the old or the new value at that index. Order is undefined but never corrupt.
- Reset mid-op: FSM returns to IDLE immediately. dst is left partially written. No op_done.

Test Plan:
- Host write 0x123 to slot 19 addr 255, read back -> host_dout = 0x123 one cycle later. Write to slot 20 -> ignored; read of slot 20 -> 0.
- Fill slot 0 with i, COPY 0->3 -> op_done exactly 257 cycles after accept; slot3[i] = i for all 256 indices; slot 0 unchanged.
- Slot1 all 3328, slot2 all 5; ADD(1,2)->4 gives 4. SUB(2,1)->5 gives 6. ADD(1,1)->6 gives 3327.
- COPY 2->2 and ADD with dst = 20 -> op_err pulse, op_ready stays 1, no slot modified. op_start during RUN -> no effect.
- During ADD into slot 4, host writes slot 4 and slot 1 -> both dropped with host_wr_drop pulses. Host write to slot 9 -> succeeds.
- Assert rst_n low at cycle 100 of a CLEAR -> op_ready=1, op_done never pulses, slot data beyond index ~99 retains old values; a subsequent CLEAR completes normally.
